// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator: per-lane I/S/B/U/J decode and extension,
// registered behind a valid/ready handshake with a one-entry skid buffer.
module imm_gen_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_en,
  input  logic [LANES*32-1:0]     in_instr,
  input  logic [LANES-1:0]        in_uns,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_en,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*3-1:0]      out_fmt,
  output logic [LANES-1:0]        out_fmt_err,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            err;
  } lane_dec_t;

  typedef struct packed {
    logic [LANES-1:0]      en;
    logic [LANES*XLEN-1:0] imm;
    logic [LANES*3-1:0]    fmt;
    logic [LANES-1:0]      err;
  } beat_t;

  // Fields are first built as 32-bit values; bits above 31 replicate ext.
  function automatic lane_dec_t decode_lane(input logic en, input logic uns,
                                            input logic [31:0] ins);
    lane_dec_t  r;
    logic       ext;
    logic [31:0] imm32;
    r     = '0;
    ext   = 1'b0;
    imm32 = '0;
    if (en) begin
      case (ins[6:2])
        OP_LUI, OP_AUIPC: begin
          r.fmt = FMT_U;
          ext   = ins[31];
          imm32 = {ins[31:12], 12'b0};
        end
        OP_IMM, OP_LOAD: begin
          r.fmt = FMT_I;
          ext   = ins[31] & ~uns;
          imm32 = {{20{ext}}, ins[31:20]};
        end
        OP_JALR: begin
          r.fmt = FMT_I;
          ext   = ins[31];
          imm32 = {{20{ext}}, ins[31:20]};
        end
        OP_STORE: begin
          r.fmt = FMT_S;
          ext   = ins[31];
          imm32 = {{20{ext}}, ins[31:25], ins[11:7]};
        end
        OP_BRANCH: begin
          r.fmt = FMT_B;
          ext   = ins[31] & ~uns;
          imm32 = {{19{ext}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        OP_JAL: begin
          r.fmt = FMT_J;
          ext   = ins[31];
          imm32 = {{11{ext}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        default: r.err = 1'b1;
      endcase
    end
    r.imm       = {XLEN{ext}};
    r.imm[31:0] = imm32;
    return r;
  endfunction

  beat_t            new_beat;
  lane_dec_t        lane_dec;
  logic             unused_opcode_lsbs;

  always_comb begin
    new_beat           = '0;
    lane_dec           = '0;
    unused_opcode_lsbs = 1'b0;
    new_beat.en        = in_lane_en;
    for (int i = 0; i < LANES; i++) begin
      lane_dec = decode_lane(in_lane_en[i], in_uns[i], in_instr[32*i +: 32]);
      new_beat.imm[XLEN*i +: XLEN] = lane_dec.imm;
      new_beat.fmt[3*i +: 3]       = lane_dec.fmt;
      new_beat.err[i]              = lane_dec.err;
      unused_opcode_lsbs = unused_opcode_lsbs ^ in_instr[32*i] ^ in_instr[32*i+1];
    end
  end

  logic             or_valid_q, or_valid_d;
  logic             sk_valid_q, sk_valid_d;
  beat_t            or_beat_q, or_beat_d;
  beat_t            sk_beat_q, sk_beat_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             accept;
  logic             or_fire;
  logic [POP_W-1:0] err_pop;
  logic [SUM_W-1:0] err_sum;

  assign accept  = in_valid & ~sk_valid_q & ~flush;
  assign or_fire = or_valid_q & out_ready;

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      err_pop = err_pop + POP_W'(new_beat.err[i]);
    end
    err_sum = SUM_W'(err_count_q) + SUM_W'(err_pop);
  end

  // A new beat goes to OR when OR is free (or draining with SK empty), else to SK.
  always_comb begin
    or_valid_d  = or_valid_q;
    sk_valid_d  = sk_valid_q;
    or_beat_d   = or_beat_q;
    sk_beat_d   = sk_beat_q;
    err_count_d = err_count_q;

    if (or_fire) begin
      if (sk_valid_q) begin
        or_beat_d  = sk_beat_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
        if (accept) begin
          sk_beat_d  = new_beat;
          sk_valid_d = 1'b1;
        end
      end else if (accept) begin
        or_beat_d  = new_beat;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (!or_valid_q) begin
      if (accept) begin
        or_beat_d  = new_beat;
        or_valid_d = 1'b1;
      end
    end else if (accept) begin
      sk_beat_d  = new_beat;
      sk_valid_d = 1'b1;
    end

    if (accept) begin
      if (err_sum > SUM_W'({CNT_W{1'b1}})) begin
        err_count_d = {CNT_W{1'b1}};
      end else begin
        err_count_d = err_sum[CNT_W-1:0];
      end
    end

    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      or_beat_q   <= '0;
      sk_beat_q   <= '0;
      err_count_q <= '0;
    end else begin
      or_valid_q  <= or_valid_d;
      sk_valid_q  <= sk_valid_d;
      or_beat_q   <= or_beat_d;
      sk_beat_q   <= sk_beat_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready    = ~sk_valid_q;
  assign out_valid   = or_valid_q;
  assign out_lane_en = or_beat_q.en;
  assign out_imm     = or_beat_q.imm;
  assign out_fmt     = or_beat_q.fmt;
  assign out_fmt_err = or_beat_q.err;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: table-driven vectors through a scoreboard
// queue, plus hand sequences for stall, drain, flush and counter saturation.
module tb_imm_gen_pipe;

  localparam int LANES   = 2;
  localparam int XLEN    = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_en = '0;
  logic [LANES*32-1:0]   in_instr = '0;
  logic [LANES-1:0]      in_uns = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [LANES-1:0]      out_lane_en;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES*3-1:0]    out_fmt;
  logic [LANES-1:0]      out_fmt_err;
  logic [CNT_W-1:0]      err_count;

  always #5 clk = ~clk;

  imm_gen_pipe #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_en(in_lane_en), .in_instr(in_instr), .in_uns(in_uns),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_en(out_lane_en), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_fmt_err(out_fmt_err), .err_count(err_count)
  );

  typedef struct packed {
    logic [1:0]       en;
    logic [1:0]       uns;
    logic [1:0][31:0] instr;
    logic [1:0][63:0] e;
    logic [1:0][2:0]  f;
    logic [1:0]       ferr;
  } vec_t;

  vec_t vecs [12];
  vec_t cur;
  vec_t v_err;
  vec_t v_idle;
  vec_t sb_q [$];
  int   model_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] en, input logic [1:0] uns,
                              input logic [31:0] i1, input logic [31:0] i0,
                              input logic [63:0] e1, input logic [63:0] e0,
                              input logic [2:0] f1, input logic [2:0] f0,
                              input logic [1:0] ferr);
    vec_t v;
    v.en = en; v.uns = uns;
    v.instr[1] = i1; v.instr[0] = i0;
    v.e[1] = e1; v.e[0] = e0;
    v.f[1] = f1; v.f[0] = f0;
    v.ferr = ferr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid);
    cur        = v;
    in_valid   = valid;
    in_lane_en = v.en;
    in_uns     = v.uns;
    in_instr   = v.instr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on fire, drop everything on flush/reset.
  always @(negedge clk or posedge rst) begin
    vec_t exp_v;
    if (rst) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      checkOutput("err_count", err_count, model_cnt);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got out_valid=1 imm=%0h, expected no beat", out_imm);
        end else begin
          exp_v = sb_q.pop_front();
          checkOutput("out_imm", out_imm, exp_v.e);
          checkOutput("out_fmt", out_fmt, exp_v.f);
          checkOutput("out_fmt_err", out_fmt_err, exp_v.ferr);
          checkOutput("out_lane_en", out_lane_en, exp_v.en);
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back(cur);
        model_cnt = model_cnt + $countones(cur.ferr);
        if (model_cnt > CNT_MAX) model_cnt = CNT_MAX;
      end
    end
  end

  initial begin
    vecs[0]  = mk(2'b01, 2'b00, 32'h0, 32'hFFF00093, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 3'd1, 2'b00);
    vecs[1]  = mk(2'b01, 2'b01, 32'h0, 32'hFFF00093, 64'h0, 64'h00000000_00000FFF, 3'd0, 3'd1, 2'b00);
    vecs[2]  = mk(2'b11, 2'b00, 32'h123450B7, 32'hFE000EE3, 64'h00000000_12345000, 64'hFFFFFFFF_FFFFFFFC, 3'd4, 3'd3, 2'b00);
    vecs[3]  = mk(2'b11, 2'b00, 32'h0010006F, 32'hFE112C23, 64'h00000000_00000800, 64'hFFFFFFFF_FFFFFFF8, 3'd5, 3'd2, 2'b00);
    vecs[4]  = mk(2'b01, 2'b00, 32'h0010006F, 32'hFE112C23, 64'h0, 64'hFFFFFFFF_FFFFFFF8, 3'd0, 3'd2, 2'b00);
    vecs[5]  = mk(2'b11, 2'b11, 32'hFFF00067, 32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00001FFC, 3'd1, 3'd3, 2'b00);
    vecs[6]  = mk(2'b11, 2'b11, 32'hFE112C23, 32'hFFF00003, 64'hFFFFFFFF_FFFFFFF8, 64'h00000000_00000FFF, 3'd2, 3'd1, 2'b00);
    vecs[7]  = mk(2'b11, 2'b11, 32'h8000006F, 32'h800000B7, 64'hFFFFFFFF_FFF00000, 64'hFFFFFFFF_80000000, 3'd5, 3'd4, 2'b00);
    vecs[8]  = mk(2'b10, 2'b00, 32'h0000007F, 32'h0000007F, 64'h0, 64'h0, 3'd0, 3'd0, 2'b10);
    vecs[9]  = mk(2'b11, 2'b00, 32'h7FF00093, 32'h00001017, 64'h00000000_000007FF, 64'h00000000_00001000, 3'd1, 3'd4, 2'b00);
    vecs[10] = mk(2'b01, 2'b00, 32'hFFF00093, 32'h00000033, 64'h0, 64'h0, 3'd0, 3'd0, 2'b01);
    vecs[11] = mk(2'b00, 2'b11, 32'hFFF00093, 32'h0000007F, 64'h0, 64'h0, 3'd0, 3'd0, 2'b00);
    v_err  = mk(2'b11, 2'b00, 32'h0000007F, 32'h0000007F, 64'h0, 64'h0, 3'd0, 3'd0, 2'b11);
    v_idle = '0;
    applyStimulus(v_idle, 1'b0);

    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_imm", out_imm, 0);
    checkOutput("rst_out_fmt", out_fmt, 0);
    checkOutput("rst_out_fmt_err", out_fmt_err, 0);
    checkOutput("rst_out_lane_en", out_lane_en, 0);
    checkOutput("rst_err_count", err_count, 0);
    step();
    step();
    rst = 1'b0;

    // Table vectors, back to back with the consumer always ready.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k], 1'b1);
      checkOutput("table_in_ready", in_ready, 1);
      step();
      checkOutput("table_latency_valid", out_valid, 1);
      checkOutput("table_out_imm_now", out_imm, vecs[k].e);
    end
    applyStimulus(v_idle, 1'b0);
    step();
    checkOutput("idle_out_valid", out_valid, 0);
    step();

    // Stall: A held in OR, B into SK, C refused, then drain A then B.
    applyStimulus(vecs[2], 1'b1);
    step();
    out_ready = 1'b0;
    applyStimulus(vecs[3], 1'b1);
    checkOutput("stall_in_ready_b", in_ready, 1);
    step();
    checkOutput("stall_in_ready_low", in_ready, 0);
    checkOutput("stall_out_valid", out_valid, 1);
    applyStimulus(vecs[7], 1'b1);
    step();
    checkOutput("stall_hold_imm", out_imm, vecs[2].e);
    checkOutput("stall_full_in_ready", in_ready, 0);
    step();
    checkOutput("stall_hold_imm2", out_imm, vecs[2].e);
    out_ready = 1'b1;
    applyStimulus(v_idle, 1'b0);
    step();
    checkOutput("drain_in_ready", in_ready, 1);
    checkOutput("drain_out_valid", out_valid, 1);
    checkOutput("drain_b_imm", out_imm, vecs[3].e);
    step();
    checkOutput("drain_empty", out_valid, 0);
    checkOutput("drain_sb_size", sb_q.size(), 0);

    // Flush with both registers full; offered beat is discarded.
    out_ready = 1'b0;
    applyStimulus(vecs[0], 1'b1);
    step();
    applyStimulus(vecs[1], 1'b1);
    step();
    applyStimulus(vecs[5], 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(v_idle, 1'b0);
    checkOutput("flush_full_out_valid", out_valid, 0);
    checkOutput("flush_full_in_ready", in_ready, 1);
    out_ready = 1'b1;
    // Flush while a beat would otherwise be accepted.
    applyStimulus(vecs[6], 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(v_idle, 1'b0);
    checkOutput("flush_discard_valid", out_valid, 0);
    // Flush coinciding with a fire.
    applyStimulus(vecs[9], 1'b1);
    step();
    applyStimulus(v_idle, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_fire_valid", out_valid, 0);
    checkOutput("flush_fire_in_ready", in_ready, 1);
    step();
    step();

    // Counter saturation after a mid-cycle async reset.
    #1 rst = 1'b1;
    #1 checkOutput("async_rst_count", err_count, 0);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(v_err, 1'b1);
      step();
      checkOutput("sat_count", err_count, (2 * k > CNT_MAX) ? CNT_MAX : 2 * k);
      checkOutput("sat_fmt_err", out_fmt_err, 2'b11);
    end
    applyStimulus(v_idle, 1'b0);
    step();
    step();

    // Reset with both registers full loses everything immediately.
    out_ready = 1'b0;
    applyStimulus(vecs[3], 1'b1);
    step();
    applyStimulus(vecs[4], 1'b1);
    step();
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_count", err_count, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_imm", out_imm, 0);
    checkOutput("midrst_out_lane_en", out_lane_en, 0);
    applyStimulus(v_idle, 1'b0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checkOutput("final_out_valid", out_valid, 0);
    checkOutput("final_sb_size", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
